// File: rtl/knn_pkg.sv
// Shared sizes, state encodings and a result check for the knn_top image server.
package knn_pkg;

  localparam int IMG_SIZE = 784;
  localparam int PIX_W    = 8;
  localparam int ADDR_W   = 10;
  localparam int LABEL_W  = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    BUSY  = 2'd3
  } buf_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    OUT   = 2'd3
  } ctrl_state_t;

  // A class index from the core is only meaningful as a digit 0..9.
  function automatic logic result_out_of_range(input logic [31:0] res);
    return (res > 32'd9);
  endfunction

endpackage

// File: rtl/knn_img_bram.sv
// Single image buffer: one write port, one registered read port with enable.
// Reads at or beyond DEPTH return 0; the read register holds when re is low.
module knn_img_bram #(
  parameter int DEPTH = knn_pkg::IMG_SIZE,
  parameter int DW    = knn_pkg::PIX_W,
  parameter int AW    = knn_pkg::ADDR_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  // Pixel storage; contents are not cleared by reset, stale data is allowed.
  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr < AW'(DEPTH))) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read with enable; out-of-range addresses read as zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= (i_raddr < AW'(DEPTH)) ? r_mem[i_raddr] : '0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/knn_image_server.sv
// Host-side responder for the HLS knn_top core: buffers streamed images,
// serves the core's image_r read port, runs the ap_ctrl_hs start handshake
// and returns the classification as a label stream.
// Build option: KNN_SRV_PINGPONG_EN selects two image buffers so the next
// image can stream in while the core reads the current one; without it a
// single buffer is used and wr_sel/rd_sel are fixed at 0.
module knn_image_server #(
  parameter int IMG_SIZE = knn_pkg::IMG_SIZE,
  parameter int PIX_W    = knn_pkg::PIX_W,
  parameter int ADDR_W   = knn_pkg::ADDR_W,
  parameter int LABEL_W  = knn_pkg::LABEL_W
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [PIX_W-1:0]   s_pix_tdata,
  input  logic               s_pix_tvalid,
  output logic               s_pix_tready,
  input  logic               s_pix_tlast,
  output logic               knn_ap_start,
  input  logic               knn_ap_ready,
  input  logic               knn_ap_idle,
  input  logic               knn_ap_done,
  input  logic [ADDR_W-1:0]  image_r_address0,
  input  logic               image_r_ce0,
  output logic [PIX_W-1:0]   image_r_q0,
  input  logic [31:0]        result,
  input  logic               result_ap_vld,
  output logic [LABEL_W-1:0] m_label_tdata,
  output logic               m_label_tvalid,
  input  logic               m_label_tready,
  output logic [1:0]         err
);

  import knn_pkg::*;

  buf_state_t         r_buf_st [2];
  ctrl_state_t        r_state;
  ctrl_state_t        w_state_nxt;
  logic [ADDR_W-1:0]  r_wr_idx;
  logic [LABEL_W-1:0] r_label;
  logic [1:0]         r_err;

  logic w_wr_sel;
  logic w_rd_sel;
  logic w_rd_pick;
  logic w_accept;
  logic w_last_idx;
  logic w_close;
  logic w_full_any;
  logic w_can_start;
  logic w_launch;
  logic w_free;

  assign w_accept    = s_pix_tvalid && s_pix_tready;
  assign w_last_idx  = (r_wr_idx == ADDR_W'(IMG_SIZE - 1));
  assign w_close     = w_accept && (s_pix_tlast || w_last_idx);
  assign w_full_any  = (r_buf_st[0] == FULL) || (r_buf_st[1] == FULL);
  assign w_can_start = w_full_any && knn_ap_idle;
  assign w_free      = (r_state == RUN) && knn_ap_done;

`ifdef KNN_SRV_PINGPONG_EN
  logic r_wr_sel;
  logic r_rd_sel;
  logic r_q_sel;
  logic [PIX_W-1:0] w_q0;
  logic [PIX_W-1:0] w_q1;

  assign w_wr_sel = r_wr_sel;
  assign w_rd_sel = r_rd_sel;
  // Writes alternate, so when both buffers are FULL the one wr_sel points
  // at was filled first; otherwise the only FULL buffer is the other one.
  assign w_rd_pick = (r_buf_st[r_wr_sel] == FULL) ? r_wr_sel : ~r_wr_sel;

  // Buffer selectors: toggle write side on close, latch read side on launch.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      if (w_close) begin
        r_wr_sel <= ~r_wr_sel;
      end
      if (w_launch) begin
        r_rd_sel <= w_rd_pick;
      end
    end
  end

  // Track which buffer produced the last read so q0 holds when ce0 is low.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_q_sel <= 1'b0;
    end else if (image_r_ce0) begin
      r_q_sel <= r_rd_sel;
    end
  end

  knn_img_bram #(.DEPTH(IMG_SIZE), .DW(PIX_W), .AW(ADDR_W)) u_bram0 (
    .i_clk   (ap_clk),
    .i_rst   (ap_rst),
    .i_we    (w_accept && (r_wr_sel == 1'b0)),
    .i_waddr (r_wr_idx),
    .i_wdata (s_pix_tdata),
    .i_re    (image_r_ce0 && (r_rd_sel == 1'b0)),
    .i_raddr (image_r_address0),
    .o_q     (w_q0)
  );

  knn_img_bram #(.DEPTH(IMG_SIZE), .DW(PIX_W), .AW(ADDR_W)) u_bram1 (
    .i_clk   (ap_clk),
    .i_rst   (ap_rst),
    .i_we    (w_accept && (r_wr_sel == 1'b1)),
    .i_waddr (r_wr_idx),
    .i_wdata (s_pix_tdata),
    .i_re    (image_r_ce0 && (r_rd_sel == 1'b1)),
    .i_raddr (image_r_address0),
    .o_q     (w_q1)
  );

  assign image_r_q0 = r_q_sel ? w_q1 : w_q0;
`else
  assign w_wr_sel  = 1'b0;
  assign w_rd_sel  = 1'b0;
  assign w_rd_pick = 1'b0;

  knn_img_bram #(.DEPTH(IMG_SIZE), .DW(PIX_W), .AW(ADDR_W)) u_bram0 (
    .i_clk   (ap_clk),
    .i_rst   (ap_rst),
    .i_we    (w_accept),
    .i_waddr (r_wr_idx),
    .i_wdata (s_pix_tdata),
    .i_re    (image_r_ce0),
    .i_raddr (image_r_address0),
    .o_q     (image_r_q0)
  );
`endif

  // Buffer life cycle EMPTY -> FILL -> FULL -> BUSY -> EMPTY, plus write index.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_buf_st[0] <= EMPTY;
      r_buf_st[1] <= EMPTY;
      r_wr_idx    <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_launch && (w_rd_pick == 1'(k))) begin
          r_buf_st[k] <= BUSY;
        end else if (w_free && (w_rd_sel == 1'(k))) begin
          r_buf_st[k] <= EMPTY;
        end else if (w_accept && (w_wr_sel == 1'(k))) begin
          r_buf_st[k] <= w_close ? FULL : FILL;
        end
      end
      if (w_accept) begin
        r_wr_idx <= w_close ? '0 : r_wr_idx + 1'b1;
      end
    end
  end

  // Sticky error flags and label capture from the core's result port.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_err   <= '0;
      r_label <= '0;
    end else begin
      if (w_close && !(s_pix_tlast && w_last_idx)) begin
        r_err[0] <= 1'b1;
      end
      if ((r_state == RUN) && result_ap_vld) begin
        r_label <= result[LABEL_W-1:0];
        if (result_out_of_range(result)) begin
          r_err[1] <= 1'b1;
        end
      end
    end
  end

  // Control state register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a label handshake may launch the next image directly.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_can_start && !m_label_tvalid) begin
          w_state_nxt = START;
          w_launch    = 1'b1;
        end
      end
      START: begin
        if (knn_ap_ready) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (knn_ap_done) begin
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        if (m_label_tready) begin
          if (w_can_start) begin
            w_state_nxt = START;
            w_launch    = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign knn_ap_start   = (r_state == START);
  assign m_label_tvalid = (r_state == OUT);
  assign m_label_tdata  = r_label;
  assign err            = r_err;
  assign s_pix_tready   = !ap_rst &&
                          ((r_buf_st[w_wr_sel] == EMPTY) || (r_buf_st[w_wr_sel] == FILL));

endmodule
